// File: rtl/expr_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : expr_stream_checker
//  Purpose  : Streaming recogniser for ASCII infix arithmetic expressions.
//             Accepts one character per cycle when in_valid is high and
//             tracks multi-digit operands, bounded parenthesis nesting and a
//             configurable operator set. ';' terminates an expression.
//             Errors are sticky until a ';' resynchronises the stream.
//  Ports    : clk       - clock, all state updates on rising edge
//             clr       - synchronous active-low reset
//             in_valid  - character on 'in' is consumed this edge
//             in        - ASCII character
//             out       - consumed characters form a complete, balanced
//                         expression
//             err       - sticky syntax error
//             done      - one-cycle pulse after an accepted ';'
//             depth     - current open-parenthesis count
//             expr_cnt  - count of accepted expressions (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module expr_stream_checker #(
  parameter int             MAX_DEPTH  = 4,
  parameter int             MAX_DIGITS = 3,
  parameter logic [3:0]     OP_MASK    = 4'b1111,
  parameter int             CNT_W      = 8
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [7:0]                       in,
  output logic                             out,
  output logic                             err,
  output logic                             done,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
  output logic [CNT_W-1:0]                 expr_cnt
);

  localparam int DW  = $clog2(MAX_DEPTH + 1);
  localparam int DCW = $clog2(MAX_DIGITS + 1);

  localparam logic [DW-1:0]  MAX_DEPTH_C  = DW'(MAX_DEPTH);
  localparam logic [DCW-1:0] MAX_DIGITS_C = DCW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_START = 2'd0,   // expecting an operand
    S_NUM   = 2'd1,   // inside a number
    S_CLOSE = 2'd2,   // just after ')'
    S_ERR   = 2'd3    // syntax error, waiting for ';'
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [DCW-1:0]   dcnt_q,  dcnt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             out_q,   out_d;
  logic             err_q,   err_d;
  logic             done_q,  done_d;

  // --------------------------------------------------------------------------
  // Character classification
  // --------------------------------------------------------------------------
  logic is_dig, is_op, is_lp, is_rp, is_term;

  always_comb begin
    is_dig  = (in >= 8'h30) && (in <= 8'h39);
    // A disabled operator falls through to the OTHER class.
    is_op   = ((in == 8'h2B) && OP_MASK[0]) ||
              ((in == 8'h2D) && OP_MASK[1]) ||
              ((in == 8'h2A) && OP_MASK[2]) ||
              ((in == 8'h2F) && OP_MASK[3]);
    is_lp   = (in == 8'h28);
    is_rp   = (in == 8'h29);
    is_term = (in == 8'h3B);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (in_valid) begin
      case (state_q)
        S_START: begin
          if (is_dig) begin
            state_d = S_NUM;
            dcnt_d  = DCW'(1);
          end else if (is_lp && (depth_q < MAX_DEPTH_C)) begin
            depth_d = depth_q + DW'(1);
          end else begin
            // Covers an empty expression (';' here) and nesting overflow.
            state_d = S_ERR;
          end
        end

        S_NUM: begin
          // Any exit from NUM clears the digit counter; only a digit that
          // still fits keeps counting.
          dcnt_d = '0;
          if (is_dig) begin
            if (dcnt_q < MAX_DIGITS_C) begin
              dcnt_d = dcnt_q + DCW'(1);
            end else begin
              state_d = S_ERR;
            end
          end else if (is_op) begin
            state_d = S_START;
          end else if (is_rp) begin
            if (depth_q != '0) begin
              depth_d = depth_q - DW'(1);
              state_d = S_CLOSE;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_term) begin
            if (depth_q == '0) begin
              state_d = S_START;
              done_d  = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end else begin
              state_d = S_ERR;
            end
          end else begin
            state_d = S_ERR;
          end
        end

        S_CLOSE: begin
          if (is_op) begin
            state_d = S_START;
          end else if (is_rp) begin
            if (depth_q != '0) begin
              depth_d = depth_q - DW'(1);
            end else begin
              state_d = S_ERR;
            end
          end else if (is_term) begin
            if (depth_q == '0) begin
              state_d = S_START;
              done_d  = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end else begin
              state_d = S_ERR;
            end
          end else begin
            state_d = S_ERR;
          end
        end

        S_ERR: begin
          // Depth is frozen at its failing value until ';' resynchronises.
          if (is_term) begin
            state_d = S_START;
            depth_d = '0;
            dcnt_d  = '0;
          end
        end

        default: begin
          state_d = S_ERR;
        end
      endcase
    end

    out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
    err_d = (state_d == S_ERR);
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_START;
      depth_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign out      = out_q;
  assign err      = err_q;
  assign done     = done_q;
  assign depth    = depth_q;
  assign expr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expr_stream_checker
//  Purpose  : Self-checking bench for expr_stream_checker. Two instances
//             (all operators / '+' and '-' only) share one character stream;
//             a rule-level model predicts both every cycle, and directed
//             literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_expr_stream_checker;

  localparam int MD  = 2;
  localparam int MG  = 2;
  localparam int DW  = $clog2(MD + 1);

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       ch = 8'h00;

  logic             out0, err0, done0;
  logic [DW-1:0]    depth0;
  logic [7:0]       cnt0;
  logic             out1, err1, done1;
  logic [DW-1:0]    depth1;
  logic [7:0]       cnt1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  expr_stream_checker #(.MAX_DEPTH(MD), .MAX_DIGITS(MG), .OP_MASK(4'b1111), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
    .out(out0), .err(err0), .done(done0), .depth(depth0), .expr_cnt(cnt0)
  );

  expr_stream_checker #(.MAX_DEPTH(MD), .MAX_DIGITS(MG), .OP_MASK(4'b0011), .CNT_W(8)) dut_m (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
    .out(out1), .err(err1), .done(done1), .depth(depth1), .expr_cnt(cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Rule-level model: operand expectation, digit run length, open parens,
  // whether the last token closed a group, and an error flag.
  // --------------------------------------------------------------------------
  bit m_bad[2];
  int m_ndig[2];
  int m_open[2];
  bit m_closed[2];
  bit e_done[2];
  int e_cnt[2];

  function automatic bit op_ok(input int k, input logic [7:0] c);
    logic [3:0] mask;
    mask = (k == 0) ? 4'b1111 : 4'b0011;
    return (c == "+" && mask[0]) || (c == "-" && mask[1]) ||
           (c == "*" && mask[2]) || (c == "/" && mask[3]);
  endfunction

  task automatic m_reset(input int k);
    m_bad[k] = 0; m_ndig[k] = 0; m_open[k] = 0; m_closed[k] = 0;
    e_done[k] = 0; e_cnt[k] = 0;
  endtask

  task automatic m_step(input int k, input logic [7:0] c);
    bit dig;
    dig = (c >= "0") && (c <= "9");
    e_done[k] = 0;
    if (m_bad[k]) begin
      if (c == ";") begin
        m_bad[k] = 0; m_open[k] = 0; m_ndig[k] = 0; m_closed[k] = 0;
      end
    end else if (m_ndig[k] == 0 && !m_closed[k]) begin
      if (dig) m_ndig[k] = 1;
      else if (c == "(" && m_open[k] < MD) m_open[k]++;
      else m_bad[k] = 1;
    end else begin
      if (dig) begin
        if (m_ndig[k] > 0 && m_ndig[k] < MG) m_ndig[k]++;
        else m_bad[k] = 1;
      end else if (op_ok(k, c)) begin
        m_ndig[k] = 0; m_closed[k] = 0;
      end else if (c == ")") begin
        if (m_open[k] > 0) begin
          m_open[k]--; m_ndig[k] = 0; m_closed[k] = 1;
        end else m_bad[k] = 1;
      end else if (c == ";") begin
        if (m_open[k] == 0) begin
          m_ndig[k] = 0; m_closed[k] = 0; e_done[k] = 1;
          e_cnt[k] = (e_cnt[k] + 1) % 256;
        end else m_bad[k] = 1;
      end else m_bad[k] = 1;
    end
  endtask

  function automatic int e_out(input int k);
    return (!m_bad[k] && (m_ndig[k] > 0 || m_closed[k]) && m_open[k] == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!clr) m_reset(k);
      else if (in_valid) m_step(k, ch);
      else e_done[k] = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0.out",   int'(out0),   e_out(0));
      chk("m0.err",   int'(err0),   int'(m_bad[0]));
      chk("m0.done",  int'(done0),  int'(e_done[0]));
      chk("m0.depth", int'(depth0), m_open[0]);
      chk("m0.cnt",   int'(cnt0),   e_cnt[0]);
      chk("m1.out",   int'(out1),   e_out(1));
      chk("m1.err",   int'(err1),   int'(m_bad[1]));
      chk("m1.done",  int'(done1),  int'(e_done[1]));
      chk("m1.depth", int'(depth1), m_open[1]);
      chk("m1.cnt",   int'(cnt1),   e_cnt[1]);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    ch       = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ch       = 8'h00;
  endtask

  task automatic stall();
    in_valid = 1'b0;
    ch       = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  int exp_out1[9] = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
  int g_out[8];
  int g_depth[8];
  int g_done[8];

  initial begin
    string s1;
    string s5;
    s1 = "12+(3*4);";
    s5 = "9*(8-7);";

    clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b1;
    chk("rst.out",   int'(out0),   0);
    chk("rst.err",   int'(err0),   0);
    chk("rst.depth", int'(depth0), 0);
    chk("rst.cnt",   int'(cnt0),   0);
    chk_en = 1'b1;

    // Well-formed expression with one nested group.
    for (int i = 0; i < s1.len(); i++) begin
      send(s1[i]);
      chk("t1.out", int'(out0), exp_out1[i]);
      chk("t1.err", int'(err0), 0);
      chk("t1.done", int'(done0), (i == 8) ? 1 : 0);
      if (i == 3) chk("t1.depth_peak", int'(depth0), 1);
    end
    chk("t1.cnt", int'(cnt0), 1);
    send(" ");
    chk("t1.done_one_cycle", int'(done0), 0);

    // Digit overflow then resync.
    do_reset();
    send_str("123");
    chk("t2.err", int'(err0), 1);
    chk("t2.out", int'(out0), 0);
    send(";");
    chk("t2.resync_err", int'(err0), 0);
    chk("t2.resync_done", int'(done0), 0);
    send("5");
    chk("t2.out5", int'(out0), 1);
    send(";");
    chk("t2.done", int'(done0), 1);
    chk("t2.cnt", int'(cnt0), 1);

    // Nesting limit.
    do_reset();
    send_str("((");
    chk("t3.depth2", int'(depth0), 2);
    chk("t3.err0", int'(err0), 0);
    send("(");
    chk("t3.err", int'(err0), 1);
    chk("t3.depth_held", int'(depth0), 2);
    send(";");
    chk("t3.resync_depth", int'(depth0), 0);
    chk("t3.resync_err", int'(err0), 0);

    // Operator after operator, unmatched ')', unbalanced ';'.
    do_reset();
    send_str("6+");
    chk("t4.noerr", int'(err0), 0);
    send("*");
    chk("t4.err_op", int'(err0), 1);
    do_reset();
    send_str("1)");
    chk("t4.err_rp", int'(err0), 1);
    do_reset();
    send_str("(1;");
    chk("t4.err_term", int'(err0), 1);
    chk("t4.depth_term", int'(depth0), 1);
    chk("t4.no_done", int'(done0), 0);
    chk("t4.cnt", int'(cnt0), 0);

    // Gap-free reference, then the same stream with stalls.
    do_reset();
    for (int i = 0; i < s5.len(); i++) begin
      send(s5[i]);
      g_out[i] = int'(out0); g_depth[i] = int'(depth0); g_done[i] = int'(done0);
    end
    chk("t5.ref_done", g_done[7], 1);
    chk("t5.ref_depth", g_depth[2], 1);
    do_reset();
    for (int i = 0; i < s5.len(); i++) begin
      send(s5[i]);
      chk("t5.out", int'(out0), g_out[i]);
      chk("t5.depth", int'(depth0), g_depth[i]);
      chk("t5.done", int'(done0), g_done[i]);
      stall();
      chk("t5.stall_done", int'(done0), 0);
      chk("t5.stall_out", int'(out0), g_out[i]);
    end
    chk("t5.cnt", int'(cnt0), 1);

    // Reset beats in_valid mid-expression.
    do_reset();
    send_str("(1+");
    in_valid = 1'b1; ch = "5"; clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b0;
    chk("t6.out", int'(out0), 0);
    chk("t6.err", int'(err0), 0);
    chk("t6.done", int'(done0), 0);
    chk("t6.depth", int'(depth0), 0);
    chk("t6.cnt", int'(cnt0), 0);
    send("7");
    chk("t6.out7", int'(out0), 1);
    chk("t6.depth7", int'(depth0), 0);

    // Restricted operator set.
    do_reset();
    send_str("6*");
    chk("t7.mask_err", int'(err1), 1);
    chk("t7.full_ok", int'(err0), 0);
    send("4");
    chk("t7.mask_sticky", int'(err1), 1);
    chk("t7.full_out", int'(out0), 1);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) send_str("1;");
    chk("t8.cnt255", int'(cnt0), 255);
    send_str("1;");
    chk("t8.wrap", int'(cnt0), 0);
    chk("t8.wrap_err", int'(err0), 0);
    chk("t8.wrap_done", int'(done0), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/expr_stream_checker.md
Name: expr_stream_checker

Overview:
- Streaming recogniser for ASCII infix arithmetic expressions, one character per accepted cycle.
- Parametrised successor of the single-digit alternating digit/operator string recogniser: adds multi-digit operands, bounded parenthesis nesting, a configurable operator set, an input-valid qualifier, ';' expression terminator with completion pulse/count, and sticky error with resynchronisation.
- Sits between the character source (UART RX / testbench byte stream) and the calculator datapath.

Parameters:
- MAX_DEPTH, 4, maximum parenthesis nesting (>=1)
- MAX_DIGITS, 3, maximum digits per operand (>=1)
- OP_MASK, 4'b1111, enabled operators: bit0 '+', bit1 '-', bit2 '*', bit3 '/'
- CNT_W, 8, width of completed-expression counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous active-low reset
- in_valid  in  1  in is consumed on this edge when 1
- in  in  8  ASCII character
- out  out  1  characters consumed so far form a complete, balanced expression
- err  out  1  syntax error, sticky until resync or reset
- done  out  1  one-cycle pulse: valid expression terminated by ';'
- depth  out  $clog2(MAX_DEPTH+1)  current open-parenthesis count
- expr_cnt  out  CNT_W  number of valid terminated expressions, wraps modulo 2^CNT_W

Behaviour:
- Reset: clr==0 at posedge -> state START, depth 0, digit count 0, out 0, err 0, done 0, expr_cnt 0. Reset has priority over in_valid.
- in_valid==0: all state, depth, out, err and expr_cnt hold; done is 0. The value of in is ignored.
- Character classes:
  - DIG '0'-'9'
  - OP: an operator whose OP_MASK bit is set; disabled operators count as OTHER
  - LP '('
  - RP ')'
  - TERM ';'
  - OTHER: everything else
- Moore outputs, registered; each reflects all characters accepted up to and including the previous edge.
- States and transitions (only on accepted characters):
  - START (expecting operand):
    - DIG -> NUM, dcnt=1
    - LP with depth<MAX_DEPTH -> depth+1, stay in START
    - LP at MAX_DEPTH -> ERR
    - RP, OP, TERM, OTHER -> ERR; this makes an empty expression an error
  - NUM (inside number):
    - DIG with dcnt<MAX_DIGITS -> dcnt+1
    - DIG with dcnt==MAX_DIGITS -> ERR
    - OP -> START
    - RP with depth>0 -> depth-1, go to CLOSE
    - RP with depth==0 -> ERR
    - TERM with depth==0 -> START, done=1 next cycle, expr_cnt+1
    - TERM with depth>0 -> ERR
    - LP, OTHER -> ERR
  - CLOSE (after ')'):
    - OP -> START
    - RP with depth>0 -> depth-1, stay in CLOSE
    - RP with depth==0 -> ERR
    - TERM: same rule as in NUM
    - DIG, LP, OTHER -> ERR
  - ERR:
    - TERM -> START with depth 0, dcnt 0; err clears on the same edge. No done pulse, expr_cnt unchanged.
    - All other characters are ignored.
- Output definitions:
  - out = (state==NUM or CLOSE) and depth==0
  - err = (state==ERR)
  - In ERR, depth holds the value it had at the failing character until resync.
- done: high for exactly the one cycle after the accepting TERM edge. Back-to-back TERM: only the first can pulse, because the second TERM arrives in START and goes to ERR.
- expr_cnt: wraps from 2^CNT_W-1 to 0 without affecting err.
- dcnt resets to 0 on every transition out of NUM.

Test Plan:
- MAX_DEPTH=2, MAX_DIGITS=2, OP_MASK=4'b1111. Stream "12+(3*4);":
  - out after each char = 1,1,0,0,0,0,0,1,0
  - depth peaks at 1
  - done=1 for one cycle after ';'
  - expr_cnt=1, err=0 throughout
- Stream "123", then ";5;":
  - err=1 after '3', out=0
  - ';' clears err; '5' gives out=1; final ';' pulses done; expr_cnt=1
- Stream "((" then "(" (MAX_DEPTH=2):
  - depth=2 after "(("
  - third '(' gives err=1
  - ";" resync gives depth=0, err=0
- Streams "6+*" and "1)":
  - err asserts on '*' and on ')' respectively
  - "(1;" gives err on ';' (depth 1), done stays 0
- Stimulus "9*(8-7);" with in_valid low on alternate cycles and random in bytes on those cycles:
  - out/depth/done sequence identical to the gap-free run
  - done is never high during a stall cycle
- Reset and OP_MASK checks:
  - "(1+", then clr=0 for one edge: all outputs 0; then "7" gives out=1, depth=0
  - OP_MASK=4'b0011, "6*4": err=1 on '*'
